// File: rtl/sentinel_trace_arb_if.sv
// Trace merge bus: N_SRC producer channels in, one merged channel out.
// The arbiter uses the slave view; the environment driving sources and sinking output uses master.
interface sentinel_trace_arb_if #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SIZE_W = 7
);
  localparam int unsigned SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        in_valid;
  logic [N_SRC-1:0]        in_ready;
  logic [N_SRC*DATA_W-1:0] in_data;
  logic [N_SRC*SIZE_W-1:0] in_size;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [SIZE_W-1:0]       out_size;
  logic [SRC_W-1:0]        out_src;
  logic [31:0]             out_seq;
  logic [31:0]             stall_cycles;

  modport slave (
    input  in_valid, in_data, in_size, out_ready,
    output in_ready, out_valid, out_data, out_size, out_src, out_seq, stall_cycles
  );

  modport master (
    output in_valid, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_data, out_size, out_src, out_seq, stall_cycles
  );
endinterface

// File: rtl/sentinel_trace_arb.sv
// Lossless round-robin merge of N_SRC trace streams into one registered output,
// tagging each record with its source index and a global merge sequence number.
module sentinel_trace_arb #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SIZE_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  sentinel_trace_arb_if.slave bus
);
  localparam int unsigned SRC_W = $clog2(N_SRC);
  localparam int unsigned SEQ_W = 32;
  localparam int unsigned CNT_W = 32;

  logic [SRC_W-1:0]  rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SIZE_W-1:0] out_size_q, out_size_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic [SEQ_W-1:0]  out_seq_q, out_seq_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [N_SRC-1:0]  grant_c;
  logic [SRC_W-1:0]  gidx_c;
  logic              gnt_any_c;
  logic              slot_free_c;
  logic              accept_c;

  // Rotating-priority search: first valid source at or after rr_q, wrapping.
  always_comb begin
    logic [SRC_W-1:0] idx;
    grant_c   = '0;
    gidx_c    = '0;
    gnt_any_c = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = SRC_W'((32'(rr_q) + k) % N_SRC);
      if (!gnt_any_c && bus.in_valid[idx]) begin
        grant_c[idx] = 1'b1;
        gidx_c       = idx;
        gnt_any_c    = 1'b1;
      end
    end
  end

  // Output slot may be refilled in the same cycle it drains; nothing is offered while in reset.
  assign slot_free_c  = !out_valid_q || bus.out_ready;
  assign accept_c     = slot_free_c && gnt_any_c && rst_n;
  assign bus.in_ready = (slot_free_c && rst_n) ? grant_c : '0;

  always_comb begin
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_size_d  = out_size_q;
    out_src_d   = out_src_q;
    out_seq_d   = out_seq_q;
    seq_d       = seq_q;
    stall_d     = stall_q;

    if (slot_free_c) begin
      out_valid_d = accept_c;
    end

    if (accept_c) begin
      out_data_d = bus.in_data[32'(gidx_c) * DATA_W +: DATA_W];
      out_size_d = bus.in_size[32'(gidx_c) * SIZE_W +: SIZE_W];
      out_src_d  = gidx_c;
      out_seq_d  = seq_q;
      seq_d      = seq_q + SEQ_W'(1);
      rr_d       = (gidx_c == SRC_W'(N_SRC - 1)) ? '0 : gidx_c + SRC_W'(1);
    end

    // Saturating count of cycles the downstream holds us off.
    if (out_valid_q && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_size_q  <= '0;
      out_src_q   <= '0;
      out_seq_q   <= '0;
      seq_q       <= '0;
      stall_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_size_q  <= out_size_d;
      out_src_q   <= out_src_d;
      out_seq_q   <= out_seq_d;
      seq_q       <= seq_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_size     = out_size_q;
  assign bus.out_src      = out_src_q;
  assign bus.out_seq      = out_seq_q;
  assign bus.stall_cycles = stall_q;

  a_in_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_size_q) &&
       $stable(out_src_q) && $stable(out_seq_q)));

  // Sources must not change a record they are still offering.
  for (genvar g = 0; g < N_SRC; g++) begin : g_src_hold
    a_src_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.in_valid[g] && !bus.in_ready[g]) |=>
        $stable(bus.in_data[g*DATA_W +: DATA_W]));
  end
endmodule
